register_file_mp: RTL and testbench

//  Parametrised multi-read-port register file, successor to the 2-read/1-write RF in the lab8 datapath.

---
 rtl/register_file_mp_if.sv | 32 +++
 rtl/register_file_mp.sv | 111 +++++++++++
 tb/tb_register_file_mp.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp_if
// Purpose  : Write/read/clear bundle between the decode stage and the RF.
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                   we;
    logic [AW-1:0]          waddr;
    logic [WIDTH-1:0]       wdata;
    logic [NREAD*AW-1:0]    raddr;
    logic [NREAD*WIDTH-1:0] rdata;
    logic                   clear_req;
    logic                   busy;

    modport master (
        output we, waddr, wdata, raddr, clear_req,
        input  rdata, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr, clear_req,
        output rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Purpose  : Multi-read-port register file with optional zero entry, write
//            bypass and a one-entry-per-cycle clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    register_file_mp_if.slave  rf_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             user_we_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (rf_bus.clear_req) begin
                    state_d   = S_CLEAR;
                    busy_d    = 1'b1;
                    clr_ptr_d = '0;
                end
            end
            S_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == C_LAST) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign user_we_w = rf_bus.we && !((ZERO_REG != 0) && (rf_bus.waddr == '0));

    // Entries are never reset; the clear engine owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (user_we_w) begin
                mem_q[rf_bus.waddr] <= rf_bus.wdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
            logic [AW-1:0]    raddr_w;
            logic [WIDTH-1:0] rdata_w;

            assign raddr_w = rf_bus.raddr[gi*AW +: AW];

            always_comb begin
                if (busy_q) begin
                    rdata_w = '0;
                end else if ((ZERO_REG != 0) && (raddr_w == '0)) begin
                    rdata_w = '0;
                end else if ((BYPASS != 0) && (state_q == S_IDLE) && rf_bus.we &&
                             (rf_bus.waddr == raddr_w)) begin
                    rdata_w = rf_bus.wdata;
                end else begin
                    rdata_w = mem_q[raddr_w];
                end
            end

            assign rf_bus.rdata[gi*WIDTH +: WIDTH] = rdata_w;
        end
    endgenerate

    assign rf_bus.busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_mp
// Purpose  : Randomised and directed checks of register_file_mp in two configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;
    logic clk = 1'b0;
    logic rst;
    logic rst2;

    always #5 clk = ~clk;

    register_file_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus  ();
    register_file_mp_if #(.WIDTH(16), .DEPTH(16), .NREAD(4)) bus2 ();

    register_file_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .rf_bus (bus)
    );

    register_file_mp #(.WIDTH(16), .DEPTH(16), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) u_dut2 (
        .clk    (clk),
        .rst    (rst2),
        .rf_bus (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a clear zeroes the whole array at once and blocks the port
    // for DEPTH edges; the one-per-cycle sweep is invisible behind busy.
    logic [31:0] m_mem [32];
    int          m_cnt = 32;

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (m_cnt > 0)                  return 32'h0;
        if (a == 5'd0)                  return 32'h0;
        if (bus.we && bus.waddr == a)   return bus.wdata;
        return m_mem[a];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_cnt = 32;
            foreach (m_mem[i]) m_mem[i] = 32'h0;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else begin
            if (bus.we && bus.waddr != 5'd0) m_mem[bus.waddr] = bus.wdata;
            if (bus.clear_req) begin
                m_cnt = 32;
                foreach (m_mem[i]) m_mem[i] = 32'h0;
            end
        end
    endtask

    task automatic do_cycle();
        @(negedge clk);
        chk("busy", 64'(bus.busy), 64'(m_cnt > 0));
        for (int p = 0; p < 2; p++)
            chk($sformatf("rd%0d", p), 64'(bus.rdata[p*32 +: 32]), 64'(exp_read(bus.raddr[p*5 +: 5])));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] r0, input logic [4:0] r1, input logic clr);
        bus.we        = w;
        bus.waddr     = wa;
        bus.wdata     = wd;
        bus.raddr     = {r1, r0};
        bus.clear_req = clr;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            do_cycle();
            n++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle2(output int n);
        n = 0;
        while (bus2.busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [4:0] wa;
        rst  = 1'b1;
        rst2 = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        bus2.we = 1'b0; bus2.waddr = '0; bus2.wdata = '0; bus2.raddr = '0; bus2.clear_req = 1'b0;

        // Reset held for two edges, then the clear sweep
        tick(); model_step();
        do_cycle();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 1'b0);
        wait_idle(n);
        chk("rst_busy_len", 64'(n), 64'd32);
        for (int a = 0; a < 32; a += 2) begin
            set_in(1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1), 1'b0);
            #1;
            chk("post_rst_rd0", 64'(bus.rdata[31:0]), 64'h0);
            chk("post_rst_rd1", 64'(bus.rdata[63:32]), 64'h0);
            do_cycle();
        end

        // Write then read on both ports
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0); do_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0); #1;
        chk("wr_rd0", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
        chk("wr_rd1", 64'(bus.rdata[63:32]), 64'hDEADBEEF);
        do_cycle();

        // Writes to entry 0 are dropped
        set_in(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0); #1;
        chk("zero_same", 64'(bus.rdata[31:0]), 64'h0);
        do_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0); #1;
        chk("zero_next", 64'(bus.rdata[31:0]), 64'h0);
        do_cycle();

        // Same-cycle bypass
        set_in(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 1'b0); do_cycle();
        set_in(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 1'b0); #1;
        chk("bypass_same", 64'(bus.rdata[31:0]), 64'h22);
        do_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0); #1;
        chk("bypass_next", 64'(bus.rdata[31:0]), 64'h22);
        do_cycle();

        // Fill, clear on request, writes during clear dropped, re-request ignored
        for (int i = 1; i < 32; i++) begin
            set_in(1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 1'b0);
            do_cycle();
        end
        set_in(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b1); do_cycle();
        chk("clr_busy", 64'(bus.busy), 64'd1);
        n = 0;
        while (bus.busy && n < 200) begin
            set_in(1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 1'(n == 5));
            do_cycle();
            n++;
        end
        chk("clr_busy_len", 64'(n), 64'd32);
        for (int a = 0; a < 32; a += 2) begin
            set_in(1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1), 1'b0);
            #1;
            chk("post_clr_rd", 64'(bus.rdata), 64'h0);
            do_cycle();
        end

        // Reset in the middle of a clear restarts it
        set_in(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b1); do_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0);
        repeat (10) do_cycle();
        rst = 1'b1; do_cycle();
        rst = 1'b0;
        wait_idle(n);
        chk("midclr_busy_len", 64'(n), 64'd32);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            wa = 5'($urandom);
            bus.we        = 1'($urandom_range(0, 1));
            bus.waddr     = wa;
            bus.wdata     = $urandom;
            for (int p = 0; p < 2; p++)
                bus.raddr[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            bus.clear_req = ($urandom_range(0, 59) == 0);
            rst           = ($urandom_range(0, 249) == 0);
            do_cycle();
        end
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);

        // Second configuration: 4 ports, 16 deep, no zero entry, no bypass
        tick();
        rst2 = 1'b0;
        #1;
        chk("c2_rst_rd", 64'(bus2.rdata), 64'h0);
        wait_idle2(n);
        chk("c2_busy_len", 64'(n), 64'd16);
        bus2.we = 1'b1; bus2.waddr = 4'd7; bus2.wdata = 16'h0011; tick();
        bus2.wdata = 16'h0022; bus2.raddr = {4{4'd7}}; #1;
        chk("c2_nobypass", 64'(bus2.rdata), {4{16'h0011}});
        tick();
        bus2.we = 1'b0; #1;
        chk("c2_wr_next", 64'(bus2.rdata), {4{16'h0022}});
        bus2.we = 1'b1; bus2.waddr = 4'd0; bus2.wdata = 16'h5A5A; tick();
        bus2.we = 1'b0; bus2.raddr = {4'd7, 4'd0, 4'd0, 4'd7}; #1;
        chk("c2_entry0", 64'(bus2.rdata), {16'h0022, 16'h5A5A, 16'h5A5A, 16'h0022});
        bus2.clear_req = 1'b1; tick();
        bus2.clear_req = 1'b0;
        chk("c2_clr_busy", 64'(bus2.busy), 64'd1);
        repeat (9) tick();
        rst2 = 1'b1; tick();
        rst2 = 1'b0;
        wait_idle2(n);
        chk("c2_midclr_len", 64'(n), 64'd16);
        #1;
        chk("c2_post_clr", 64'(bus2.rdata), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
